ldst_arb: RTL and testbench

Two-master arbiter that shares the single load/store memory port between the instruction-fetch requester (master 0, IFU) and the data requester (master 1, EXU `ldst_src`). It performs round-robin request arbitration with grant locking, and tracks up to OST outstanding transactions in an owner FIFO so that in-order responses return to the issuing master. It sits between the core front/back end and the memory/bus adapter.

---
 rtl/ldst_arb_pkg.sv | 27 ++
 rtl/ldst_owner_fifo.sv | 72 +++++++
 rtl/ldst_arb.sv | 129 ++++++++++++
 tb/tb_ldst_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldst_arb_pkg.sv
// rtl/ldst_arb_pkg.sv - shared types and constants for the load/store port arbiter
//
// Purpose : request payload struct, master index constants and a pointer-width
//           helper used by ldst_arb and ldst_owner_fifo.
// Ports   : none (package)
package ldst_arb_pkg;

    localparam int LDST_AW = 32;
    localparam int LDST_DW = 32;

    // Master indices as seen on the per-master vectors
    localparam logic LDST_M_IFU = 1'b0;
    localparam logic LDST_M_EXU = 1'b1;

    typedef struct packed {
        logic [LDST_AW-1:0]   addr;
        logic                 wr;
        logic [LDST_DW-1:0]   wdata;
        logic [LDST_DW/8-1:0] strb;
    } ldst_req_t;

    // Pointer width for a FIFO of the given depth; never narrower than one bit
    function automatic int ldst_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ldst_owner_fifo.sv
// rtl/ldst_owner_fifo.sv - owner-index FIFO recording which master issued each outstanding request
//
// Purpose : OST-deep FIFO of 1-bit master indices; full/empty come from the
//           registered count only, so a same-cycle pop never frees a slot for a push.
// Ports   : clk, rst (sync, active-high)
//           push, din   - enqueue the granted master index
//           pop, dout   - dequeue / current head index
//           full, empty - registered occupancy flags
module ldst_owner_fifo
    import ldst_arb_pkg::*;
#(
    parameter int OST = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PW = ldst_ptr_w(OST);
    localparam int CW = $clog2(OST + 1);
    localparam int MD = 1 << PW;

    logic          mem [MD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(OST));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap modulo OST, which need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OST - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ldst_arb.sv
// rtl/ldst_arb.sv - two-master round-robin arbiter for the shared load/store memory port
//
// Purpose : grants IFU (master 0) or EXU (master 1) onto the single memory
//           request port with round-robin tie-break and grant locking under
//           backpressure, and routes in-order responses back via an owner FIFO.
// Ports   : clk, rst (sync, active-high)
//           m_req_*    - per-master request (vld/rdy, addr, wr, wdata, strb)
//           m_rsp_*    - per-master response (vld/rdy) and shared data
//           s_req_*    - memory-side request, payload of the granted master
//           s_rsp_*    - memory-side response
//           rsp_orphan - sticky: a response arrived with nothing outstanding
module ldst_arb
    import ldst_arb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int OST = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_req_vld,
    output logic [1:0]          m_req_rdy,
    input  logic [2*AW-1:0]     m_req_addr,
    input  logic [1:0]          m_req_wr,
    input  logic [2*DW-1:0]     m_req_wdata,
    input  logic [2*DW/8-1:0]   m_req_strb,
    output logic [1:0]          m_rsp_vld,
    input  logic [1:0]          m_rsp_rdy,
    output logic [DW-1:0]       m_rsp_data,
    output logic                s_req_vld,
    input  logic                s_req_rdy,
    output logic [AW-1:0]       s_req_addr,
    output logic                s_req_wr,
    output logic [DW-1:0]       s_req_wdata,
    output logic [DW/8-1:0]     s_req_strb,
    input  logic                s_rsp_vld,
    output logic                s_rsp_rdy,
    input  logic [DW-1:0]       s_rsp_data,
    output logic                rsp_orphan
);

    localparam int SW = DW / 8;

    logic last;
    logic lock;
    logic lock_id;
    logic gnt;
    logic full;
    logic empty;
    logic head;
    logic req_ok;
    logic rsp_ok;
    logic req_hs;
    logic rsp_hs;

    // A stalled request keeps its grant so the memory side sees a stable payload
    always_comb begin
        gnt = ~last;
        if (lock) begin
            gnt = lock_id;
        end else begin
            case (m_req_vld)
                2'b01:   gnt = LDST_M_IFU;
                2'b10:   gnt = LDST_M_EXU;
                default: gnt = ~last;
            endcase
        end
    end

    // Holding rst keeps every handshake output low
    assign req_ok    = ~full & ~rst;
    assign rsp_ok    = ~empty & ~rst;

    assign s_req_vld = m_req_vld[gnt] & req_ok;
    assign req_hs    = s_req_vld & s_req_rdy;

    always_comb begin
        m_req_rdy      = 2'b00;
        m_req_rdy[gnt] = s_req_rdy & req_ok;
    end

    assign s_req_addr  = gnt ? m_req_addr[2*AW-1:AW]  : m_req_addr[AW-1:0];
    assign s_req_wr    = gnt ? m_req_wr[1]            : m_req_wr[0];
    assign s_req_wdata = gnt ? m_req_wdata[2*DW-1:DW] : m_req_wdata[DW-1:0];
    assign s_req_strb  = gnt ? m_req_strb[2*SW-1:SW]  : m_req_strb[SW-1:0];

    always_comb begin
        m_rsp_vld       = 2'b00;
        m_rsp_vld[head] = s_rsp_vld & rsp_ok;
    end

    assign s_rsp_rdy  = m_rsp_rdy[head] & rsp_ok;
    assign rsp_hs     = s_rsp_vld & s_rsp_rdy;
    assign m_rsp_data = s_rsp_data;

    ldst_owner_fifo #(
        .OST (OST)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_hs),
        .din   (gnt),
        .pop   (rsp_hs),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= 1'b1;
            lock       <= 1'b0;
            lock_id    <= 1'b0;
            rsp_orphan <= 1'b0;
        end else begin
            if (req_hs) begin
                last <= gnt;
                lock <= 1'b0;
            end else if (s_req_vld) begin
                lock    <= 1'b1;
                lock_id <= gnt;
            end
            if (s_rsp_vld && empty) begin
                rsp_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ldst_arb.sv
// tb/tb_ldst_arb.sv - self-checking bench for ldst_arb
module tb_ldst_arb;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int OST = 4;
    localparam int SW  = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        m_req_vld;
    logic [1:0]        m_req_rdy;
    logic [2*AW-1:0]   m_req_addr;
    logic [1:0]        m_req_wr;
    logic [2*DW-1:0]   m_req_wdata;
    logic [2*SW-1:0]   m_req_strb;
    logic [1:0]        m_rsp_vld;
    logic [1:0]        m_rsp_rdy;
    logic [DW-1:0]     m_rsp_data;
    logic              s_req_vld;
    logic              s_req_rdy;
    logic [AW-1:0]     s_req_addr;
    logic              s_req_wr;
    logic [DW-1:0]     s_req_wdata;
    logic [SW-1:0]     s_req_strb;
    logic              s_rsp_vld;
    logic              s_rsp_rdy;
    logic [DW-1:0]     s_rsp_data;
    logic              rsp_orphan;

    int checks   = 0;
    int failures = 0;

    ldst_arb #(.AW(AW), .DW(DW), .OST(OST)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_vld   (m_req_vld),
        .m_req_rdy   (m_req_rdy),
        .m_req_addr  (m_req_addr),
        .m_req_wr    (m_req_wr),
        .m_req_wdata (m_req_wdata),
        .m_req_strb  (m_req_strb),
        .m_rsp_vld   (m_rsp_vld),
        .m_rsp_rdy   (m_rsp_rdy),
        .m_rsp_data  (m_rsp_data),
        .s_req_vld   (s_req_vld),
        .s_req_rdy   (s_req_rdy),
        .s_req_addr  (s_req_addr),
        .s_req_wr    (s_req_wr),
        .s_req_wdata (s_req_wdata),
        .s_req_strb  (s_req_strb),
        .s_rsp_vld   (s_rsp_vld),
        .s_rsp_rdy   (s_rsp_rdy),
        .s_rsp_data  (s_rsp_data),
        .rsp_orphan  (rsp_orphan)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_req_vld   = 2'b00;
        m_req_addr  = '0;
        m_req_wr    = 2'b00;
        m_req_wdata = '0;
        m_req_strb  = '0;
        m_rsp_rdy   = 2'b00;
        s_req_rdy   = 1'b0;
        s_rsp_vld   = 1'b0;
        s_rsp_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_req_vld = 2'b11;
        s_req_rdy = 1'b1;
        s_rsp_vld = 1'b1;
        m_rsp_rdy = 2'b11;
        cyc();
        cyc();
        #1;
        checks++; if (s_req_vld !== 1'b0) begin failures++; $display("FAIL reset_s_req_vld got=%b exp=0", s_req_vld); end
        checks++; if (m_req_rdy !== 2'b00) begin failures++; $display("FAIL reset_m_req_rdy got=%b exp=00", m_req_rdy); end
        checks++; if (m_rsp_vld !== 2'b00) begin failures++; $display("FAIL reset_m_rsp_vld got=%b exp=00", m_rsp_vld); end
        checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL reset_s_rsp_rdy got=%b exp=0", s_rsp_rdy); end
        checks++; if (rsp_orphan !== 1'b0) begin failures++; $display("FAIL reset_orphan got=%b exp=0", rsp_orphan); end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        m_req_vld = 2'b01;
        m_req_addr[AW-1:0] = 32'h100;
        s_req_rdy = 1'b1;
        #1;
        checks++; if (s_req_addr !== 32'h100) begin failures++; $display("FAIL single_addr got=%h exp=100", s_req_addr); end
        checks++; if (m_req_rdy !== 2'b01) begin failures++; $display("FAIL single_m_req_rdy got=%b exp=01", m_req_rdy); end
        checks++; if (s_req_vld !== 1'b1) begin failures++; $display("FAIL single_s_req_vld got=%b exp=1", s_req_vld); end
        cyc();
        m_req_vld  = 2'b00;
        s_rsp_vld  = 1'b1;
        s_rsp_data = 32'hDEADBEEF;
        m_rsp_rdy  = 2'b01;
        #1;
        checks++; if (m_rsp_vld !== 2'b01) begin failures++; $display("FAIL single_m_rsp_vld got=%b exp=01", m_rsp_vld); end
        checks++; if (m_rsp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rsp_data got=%h exp=deadbeef", m_rsp_data); end
        checks++; if (s_rsp_rdy !== 1'b1) begin failures++; $display("FAIL single_s_rsp_rdy got=%b exp=1", s_rsp_rdy); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        m_req_vld = 2'b11;
        m_req_addr = {32'hB0, 32'hA0};
        s_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (s_req_addr !== ((i % 2 == 0) ? 32'hA0 : 32'hB0)) begin
                failures++; $display("FAIL contention_addr_%0d got=%h exp=%h", i, s_req_addr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
            end
            checks++;
            if (m_req_rdy !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                failures++; $display("FAIL contention_rdy_%0d got=%b exp=%b", i, m_req_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            cyc();
        end
        #1;
        checks++; if (s_req_vld !== 1'b0) begin failures++; $display("FAIL contention_full_vld got=%b exp=0", s_req_vld); end
        checks++; if (m_req_rdy !== 2'b00) begin failures++; $display("FAIL contention_full_rdy got=%b exp=00", m_req_rdy); end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        m_req_vld = 2'b10;
        m_req_addr = {32'hB4, 32'h0};
        s_req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                m_req_vld = 2'b11;
                m_req_addr[AW-1:0] = 32'hA4;
            end
            #1;
            checks++; if (s_req_addr !== 32'hB4) begin failures++; $display("FAIL lock_addr_%0d got=%h exp=b4", i, s_req_addr); end
            checks++; if (s_req_vld !== 1'b1) begin failures++; $display("FAIL lock_vld_%0d got=%b exp=1", i, s_req_vld); end
            cyc();
        end
        s_req_rdy = 1'b1;
        #1;
        checks++; if (s_req_addr !== 32'hB4) begin failures++; $display("FAIL lock_release_addr got=%h exp=b4", s_req_addr); end
        checks++; if (m_req_rdy !== 2'b10) begin failures++; $display("FAIL lock_release_rdy got=%b exp=10", m_req_rdy); end
        cyc();
        m_req_vld = 2'b01;
        #1;
        checks++; if (s_req_addr !== 32'hA4) begin failures++; $display("FAIL lock_next_addr got=%h exp=a4", s_req_addr); end
        checks++; if (m_req_rdy !== 2'b01) begin failures++; $display("FAIL lock_next_rdy got=%b exp=01", m_req_rdy); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_full_boundary();
        do_reset();
        m_req_vld = 2'b01;
        s_req_rdy = 1'b1;
        for (int i = 0; i < OST; i++) cyc();
        m_req_vld = 2'b10;
        s_rsp_vld = 1'b1;
        m_rsp_rdy = 2'b01;
        #1;
        checks++; if (s_rsp_rdy !== 1'b1) begin failures++; $display("FAIL full_pop_rdy got=%b exp=1", s_rsp_rdy); end
        checks++; if (m_req_rdy !== 2'b00) begin failures++; $display("FAIL full_same_cycle_rdy got=%b exp=00", m_req_rdy); end
        checks++; if (s_req_vld !== 1'b0) begin failures++; $display("FAIL full_same_cycle_vld got=%b exp=0", s_req_vld); end
        cyc();
        s_rsp_vld = 1'b0;
        #1;
        checks++; if (m_req_rdy !== 2'b10) begin failures++; $display("FAIL full_next_rdy got=%b exp=10", m_req_rdy); end
        checks++; if (s_req_vld !== 1'b1) begin failures++; $display("FAIL full_next_vld got=%b exp=1", s_req_vld); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_routing();
        do_reset();
        s_req_rdy = 1'b1;
        m_req_vld = 2'b01;
        cyc();
        m_req_vld = 2'b10;
        cyc();
        m_req_vld = 2'b00;
        s_rsp_vld = 1'b1;
        s_rsp_data = 32'h1111;
        m_rsp_rdy = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL route_bp_rdy_%0d got=%b exp=0", i, s_rsp_rdy); end
            checks++; if (m_rsp_vld !== 2'b01) begin failures++; $display("FAIL route_bp_vld_%0d got=%b exp=01", i, m_rsp_vld); end
            cyc();
        end
        m_rsp_rdy = 2'b01;
        #1;
        checks++; if (s_rsp_rdy !== 1'b1) begin failures++; $display("FAIL route_first_rdy got=%b exp=1", s_rsp_rdy); end
        cyc();
        s_rsp_data = 32'h2222;
        m_rsp_rdy = 2'b10;
        #1;
        checks++; if (m_rsp_vld !== 2'b10) begin failures++; $display("FAIL route_second_vld got=%b exp=10", m_rsp_vld); end
        checks++; if (s_rsp_rdy !== 1'b1) begin failures++; $display("FAIL route_second_rdy got=%b exp=1", s_rsp_rdy); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_orphan();
        do_reset();
        s_req_rdy = 1'b1;
        m_req_vld = 2'b01;
        cyc();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        s_rsp_vld = 1'b1;
        m_rsp_rdy = 2'b11;
        #1;
        checks++; if (s_rsp_rdy !== 1'b0) begin failures++; $display("FAIL orphan_rdy got=%b exp=0", s_rsp_rdy); end
        checks++; if (m_rsp_vld !== 2'b00) begin failures++; $display("FAIL orphan_vld got=%b exp=00", m_rsp_vld); end
        cyc();
        s_rsp_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky_%0d got=%b exp=1", i, rsp_orphan); end
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (rsp_orphan !== 1'b0) begin failures++; $display("FAIL orphan_clear got=%b exp=0", rsp_orphan); end
        idle_inputs();
    endtask

    // Reference: outstanding owners as a queue, memory returns responses in issue order,
    // each master expects its own data back in the order it issued.
    task automatic test_random();
        int          own_q[$];
        logic [31:0] mem_q[$];
        logic [31:0] exp_q0[$];
        logic [31:0] exp_q1[$];
        logic        pend[2];
        logic [31:0] r_addr[2];
        logic [31:0] r_wdata[2];
        logic        r_wr[2];
        logic [3:0]  r_strb[2];
        logic        last_m, lock_m, lock_id_m;
        int          g, head;
        logic        e_full, e_empty, e_sv, e_srr;
        logic [1:0]  e_mrr, e_mrv;
        logic [31:0] d;

        do_reset();
        last_m = 1'b1; lock_m = 1'b0; lock_id_m = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cycle = 0; cycle < 3000; cycle++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && ($urandom % 3 == 0)) begin
                    pend[k]    = 1'b1;
                    r_addr[k]  = $urandom & 32'hFFFF_FFFC;
                    r_wr[k]    = 1'($urandom % 2);
                    r_wdata[k] = $urandom;
                    r_strb[k]  = 4'($urandom);
                end
            end
            m_req_vld   = {pend[1], pend[0]};
            m_req_addr  = {r_addr[1], r_addr[0]};
            m_req_wr    = {r_wr[1], r_wr[0]};
            m_req_wdata = {r_wdata[1], r_wdata[0]};
            m_req_strb  = {r_strb[1], r_strb[0]};
            s_req_rdy   = ($urandom % 4 != 0);
            s_rsp_vld   = (mem_q.size() > 0) && ($urandom % 2 == 0);
            s_rsp_data  = (mem_q.size() > 0) ? mem_q[0] : $urandom;
            m_rsp_rdy   = 2'($urandom);
            #1;
            e_full  = (own_q.size() == OST);
            e_empty = (own_q.size() == 0);
            if (lock_m) g = int'(lock_id_m);
            else if (pend[0] && pend[1]) g = last_m ? 0 : 1;
            else g = pend[1] ? 1 : 0;
            e_sv  = pend[g] && !e_full;
            e_mrr = (s_req_rdy && !e_full) ? (2'b01 << g) : 2'b00;
            head  = e_empty ? 0 : own_q[0];
            e_mrv = (s_rsp_vld && !e_empty) ? (2'b01 << head) : 2'b00;
            e_srr = !e_empty && m_rsp_rdy[head];

            checks++; if (s_req_vld !== e_sv) begin failures++; $display("FAIL rnd_s_req_vld c=%0d got=%b exp=%b", cycle, s_req_vld, e_sv); end
            checks++; if ((m_req_rdy & m_req_vld) !== (e_mrr & m_req_vld)) begin failures++; $display("FAIL rnd_m_req_rdy c=%0d got=%b exp=%b", cycle, m_req_rdy & m_req_vld, e_mrr & m_req_vld); end
            if (e_sv) begin
                checks++;
                if ({s_req_addr, s_req_wr, s_req_wdata, s_req_strb} !== {r_addr[g], r_wr[g], r_wdata[g], r_strb[g]}) begin
                    failures++; $display("FAIL rnd_payload c=%0d got=%h exp=%h", cycle, s_req_addr, r_addr[g]);
                end
            end
            checks++; if (m_rsp_vld !== e_mrv) begin failures++; $display("FAIL rnd_m_rsp_vld c=%0d got=%b exp=%b", cycle, m_rsp_vld, e_mrv); end
            checks++; if (s_rsp_rdy !== e_srr) begin failures++; $display("FAIL rnd_s_rsp_rdy c=%0d got=%b exp=%b", cycle, s_rsp_rdy, e_srr); end

            for (int k = 0; k < 2; k++) begin
                if (m_rsp_vld[k] && m_rsp_rdy[k]) begin
                    checks++;
                    if (k == 0 && exp_q0.size() > 0) d = exp_q0.pop_front();
                    else if (k == 1 && exp_q1.size() > 0) d = exp_q1.pop_front();
                    else d = 32'hxxxx_xxxx;
                    if (m_rsp_data !== d) begin failures++; $display("FAIL rnd_rsp_data m%0d c=%0d got=%h exp=%h", k, cycle, m_rsp_data, d); end
                end
            end

            if (s_rsp_vld && e_srr) begin
                void'(own_q.pop_front());
                void'(mem_q.pop_front());
            end
            if (e_sv && s_req_rdy) begin
                d = $urandom;
                own_q.push_back(g);
                mem_q.push_back(d);
                if (g == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
                last_m  = 1'(g);
                lock_m  = 1'b0;
                pend[g] = 1'b0;
            end else if (e_sv) begin
                lock_m    = 1'b1;
                lock_id_m = 1'(g);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_full_boundary();
        test_routing();
        test_orphan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
